// File: rtl/cp0_regfile.sv
// -----------------------------------------------------------------------------
// cp0_regfile
// Coprocessor-0 register file for the MIPS core. Holds BadVAddr, Count,
// Compare, Status, Cause, EPC and PRId, services MTC0/MFC0, commits the
// exception decided in the memory stage (EPC/Cause/BadVAddr update, EXL set),
// handles ERET (EXL clear) and produces the timer and pending-interrupt flags.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   we_i, waddr_i, data_i    MTC0 write port
//   raddr_i, data_o          MFC0 read port (combinational, no write bypass)
//   int_i                    level-sensitive hardware interrupt lines
//   except_type_i            committed exception code (0 = none, 0xe = ERET)
//   current_inst_addr_i      PC of the excepting instruction
//   is_in_delayslot_i        excepting instruction sits in a delay slot
//   bad_addr_i               faulting virtual address for AdEL/AdES
//   status_o .. compare_o    current register values
//   timer_int_o              Count == Compare timer flag
//   int_pending_o            enabled and unmasked interrupt is pending
// -----------------------------------------------------------------------------
module cp0_regfile #(
    parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o,
    output logic        int_pending_o
);

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [4:0]  REG_PRID     = 5'd15;

    // Status bits software may change: IM[15:8], EXL[1], IE[0]
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    // Codes that perform an exception entry; anything else nonzero is a no-op
    function automatic logic is_exc_entry(input logic [31:0] code);
        case (code)
            32'h0000_0001, 32'h0000_0004, 32'h0000_0005,
            32'h0000_0008, 32'h0000_0009, 32'h0000_000a,
            32'h0000_000c: return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q,    count_d;
    logic [31:0] compare_q,  compare_d;
    logic [31:0] status_q,   status_d;
    logic [31:0] cause_q,    cause_d;
    logic [31:0] epc_q,      epc_d;
    logic        tick_q,     tick_d;
    logic        timer_int_q, timer_int_d;

    logic        mtc0_s;
    logic        exc_s;
    logic        eret_s;

    // Next-state logic for every CP0 register
    always_comb begin
        // A nonzero exception code flushes the MTC0 instruction in this stage
        mtc0_s = we_i && (except_type_i == 32'd0);
        exc_s  = is_exc_entry(except_type_i);
        eret_s = (except_type_i == EXC_ERET);

        tick_d = ~tick_q;

        if (mtc0_s && (waddr_i == REG_COUNT)) begin
            count_d = data_i;
        end else if (tick_q) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end

        if (mtc0_s && (waddr_i == REG_COMPARE)) begin
            compare_d = data_i;
        end else begin
            compare_d = compare_q;
        end

        // Writing Compare acknowledges the timer and beats a same-cycle match
        if (mtc0_s && (waddr_i == REG_COMPARE)) begin
            timer_int_d = 1'b0;
        end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
            timer_int_d = 1'b1;
        end else begin
            timer_int_d = timer_int_q;
        end

        status_d = status_q;
        if (mtc0_s && (waddr_i == REG_STATUS)) begin
            status_d = (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
        end else if (exc_s) begin
            status_d[1] = 1'b1;
        end else if (eret_s) begin
            status_d[1] = 1'b0;
        end else begin
            status_d = status_q;
        end

        cause_d = cause_q;
        // Hardware IP is sampled every cycle; the timer shares line 5
        cause_d[15:10] = {int_i[5] | timer_int_q, int_i[4:0]};
        if (mtc0_s && (waddr_i == REG_CAUSE)) begin
            cause_d[9:8] = data_i[9:8];
        end else if (exc_s) begin
            cause_d[6:2] = (except_type_i == EXC_INT) ? 5'd0 : except_type_i[4:0];
            if (!status_q[1]) begin
                cause_d[31] = is_in_delayslot_i;
            end else begin
                cause_d[31] = cause_q[31];
            end
        end else begin
            cause_d[9:8] = cause_q[9:8];
        end

        // Nested exceptions (EXL already set) keep the original return address
        if (mtc0_s && (waddr_i == REG_EPC)) begin
            epc_d = data_i;
        end else if (exc_s && !status_q[1]) begin
            epc_d = is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;
        end else begin
            epc_d = epc_q;
        end

        if (exc_s && ((except_type_i == EXC_ADEL) || (except_type_i == EXC_ADES))) begin
            badvaddr_d = bad_addr_i;
        end else begin
            badvaddr_d = badvaddr_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q  <= 32'd0;
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            status_q    <= STATUS_RESET;
            cause_q     <= 32'd0;
            epc_q       <= 32'd0;
            tick_q      <= 1'b0;
            timer_int_q <= 1'b0;
        end else begin
            badvaddr_q  <= badvaddr_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            status_q    <= status_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            tick_q      <= tick_d;
            timer_int_q <= timer_int_d;
        end
    end

    // MFC0 read mux; unmapped registers read as zero
    always_comb begin
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr_q;
            REG_COUNT:    data_o = count_q;
            REG_COMPARE:  data_o = compare_q;
            REG_STATUS:   data_o = status_q;
            REG_CAUSE:    data_o = cause_q;
            REG_EPC:      data_o = epc_q;
            REG_PRID:     data_o = PRID_VALUE;
            default:      data_o = 32'd0;
        endcase
    end

    assign status_o      = status_q;
    assign cause_o       = cause_q;
    assign epc_o         = epc_q;
    assign badvaddr_o    = badvaddr_q;
    assign count_o       = count_q;
    assign compare_o     = compare_q;
    assign timer_int_o   = timer_int_q;
    assign int_pending_o = status_q[0] & ~status_q[1] & (|(status_q[15:8] & cause_q[15:8]));

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] except_type_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
    logic        timer_int_o, int_pending_o;

    cp0_regfile dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .int_i(int_i), .except_type_i(except_type_i),
        .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
        .bad_addr_i(bad_addr_i), .data_o(data_o), .status_o(status_o), .cause_o(cause_o),
        .epc_o(epc_o), .badvaddr_o(badvaddr_o), .count_o(count_o), .compare_o(compare_o),
        .timer_int_o(timer_int_o), .int_pending_o(int_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] status, cause, epc, badv, count, compare, data;
        logic        timer, pend;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: architectural fields kept separately
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd;
    logic [5:0]  m_ip_hw;
    logic [1:0]  m_ip_sw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_bad, m_count, m_compare;
    logic        m_timer;
    int          m_phase;          // edges since reset; Count advances on odd ones
    logic [5:0]  g_int = 6'd0;     // current level of the interrupt lines

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'h0040_0000;
        s[15:8] = m_im;
        s[1] = m_exl;
        s[0] = m_ie;
        return s;
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, 15'd0, m_ip_hw, m_ip_sw, 1'b0, m_exc, 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] ra);
        case (ra)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_4220;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] d,
                              input logic [5:0] ii, input logic [31:0] code, input logic [31:0] pc,
                              input bit ds, input logic [31:0] ba);
        bit mt, is_exc;
        logic n_timer;
        logic [31:0] n_count;
        if (r) begin
            m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
            m_ip_hw = 6'd0; m_ip_sw = 2'd0; m_exc = 5'd0;
            m_epc = 32'd0; m_bad = 32'd0; m_count = 32'd0; m_compare = 32'd0;
            m_timer = 1'b0; m_phase = 0;
        end else begin
            mt = we && (code == 32'd0);
            is_exc = (code == 32'h1) || (code == 32'h4) || (code == 32'h5) || (code == 32'h8) ||
                     (code == 32'h9) || (code == 32'ha) || (code == 32'hc);
            if (mt && wa == 5'd11) n_timer = 1'b0;
            else if (m_compare != 32'd0 && m_count == m_compare) n_timer = 1'b1;
            else n_timer = m_timer;
            if (mt && wa == 5'd9) n_count = d;
            else n_count = m_count + ((m_phase % 2 == 1) ? 32'd1 : 32'd0);
            m_ip_hw = {ii[5] | m_timer, ii[4:0]};
            if (mt) begin
                case (wa)
                    5'd11: m_compare = d;
                    5'd12: begin m_im = d[15:8]; m_exl = d[1]; m_ie = d[0]; end
                    5'd13: m_ip_sw = d[9:8];
                    5'd14: m_epc = d;
                    default: ;
                endcase
            end
            if (is_exc) begin
                if (!m_exl) begin
                    m_epc = ds ? pc - 32'd4 : pc;
                    m_bd  = ds;
                end
                m_exl = 1'b1;
                m_exc = (code == 32'h1) ? 5'd0 : code[4:0];
                if (code == 32'h4 || code == 32'h5) m_bad = ba;
            end else if (code == 32'he) begin
                m_exl = 1'b0;
            end
            m_timer = n_timer;
            m_count = n_count;
            m_phase++;
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the edge
    task automatic step(input bit r, input bit we, input logic [4:0] wa, input logic [4:0] ra,
                        input logic [31:0] d, input logic [5:0] ii, input logic [31:0] code,
                        input logic [31:0] pc, input bit ds, input logic [31:0] ba);
        exp_t e;
        @(negedge clk);
        rst = r; we_i = we; waddr_i = wa; raddr_i = ra; data_i = d; int_i = ii;
        except_type_i = code; current_inst_addr_i = pc; is_in_delayslot_i = ds; bad_addr_i = ba;
        model_step(r, we, wa, d, ii, code, pc, ds, ba);
        e.status = m_status(); e.cause = m_cause(); e.epc = m_epc; e.badv = m_bad;
        e.count = m_count; e.compare = m_compare; e.timer = m_timer;
        e.pend = m_ie & ~m_exl & (|(m_im & {m_ip_hw, m_ip_sw}));
        e.data = m_read(ra);
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [4:0] ra);
        step(1'b0, 1'b0, 5'd0, ra, 32'd0, g_int, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] d);
        step(1'b0, 1'b1, wa, wa, d, g_int, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic exc(input logic [31:0] code, input logic [31:0] pc, input bit ds, input logic [31:0] ba);
        step(1'b0, 1'b0, 5'd0, 5'd14, 32'd0, g_int, code, pc, ds, ba);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every output against the queued expectation after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("status", status_o, e.status);
                chk("cause", cause_o, e.cause);
                chk("epc", epc_o, e.epc);
                chk("badvaddr", badvaddr_o, e.badv);
                chk("count", count_o, e.count);
                chk("compare", compare_o, e.compare);
                chk("timer_int", {31'd0, timer_int_o}, {31'd0, e.timer});
                chk("int_pending", {31'd0, int_pending_o}, {31'd0, e.pend});
                chk("data_o", data_o, e.data);
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        logic [4:0]  regs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        logic [31:0] codes [10] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he, 32'h3, 32'h20};
        bit seen;
        rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; raddr_i = 5'd0; data_i = 32'd0; int_i = 6'd0;
        except_type_i = 32'd0; current_inst_addr_i = 32'd0; is_in_delayslot_i = 1'b0; bad_addr_i = 32'd0;

        step(1'b1, 1'b0, 5'd0, 5'd12, 32'd0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 5'd12, 5'd12, 32'hFFFF_FFFF, 6'h3f, 32'h4, 32'h1234, 1'b1, 32'h55);
        settle();
        chk("reset_status", data_o, 32'h0040_0000);
        chk("reset_timer", {31'd0, timer_int_o}, 32'd0);
        chk("reset_pending", {31'd0, int_pending_o}, 32'd0);
        idle(5'd13); settle(); chk("reset_cause", data_o, 32'd0);
        idle(5'd15); settle(); chk("prid", data_o, 32'h0000_4220);

        mtc0(5'd12, 32'h0000_FF01);
        g_int = 6'b000001;
        idle(5'd13); settle();
        chk("ip10", {31'd0, cause_o[10]}, 32'd1);
        chk("pending_on", {31'd0, int_pending_o}, 32'd1);
        exc(32'h1, 32'hbfc0_1000, 1'b0, 32'd0); settle();
        chk("int_epc", epc_o, 32'hbfc0_1000);
        chk("int_exl", {31'd0, status_o[1]}, 32'd1);
        chk("int_exccode", {27'd0, cause_o[6:2]}, 32'd0);
        chk("pending_exl", {31'd0, int_pending_o}, 32'd0);
        exc(32'he, 32'd0, 1'b0, 32'd0); settle();
        chk("eret_exl", {31'd0, status_o[1]}, 32'd0);

        exc(32'h4, 32'h8000_0010, 1'b1, 32'h8000_0003); settle();
        chk("adel_epc", epc_o, 32'h8000_000c);
        chk("adel_bd", {31'd0, cause_o[31]}, 32'd1);
        chk("adel_exccode", {27'd0, cause_o[6:2]}, 32'd4);
        chk("adel_badv", badvaddr_o, 32'h8000_0003);
        exc(32'h5, 32'h8000_0100, 1'b0, 32'h0000_1234); settle();
        chk("nested_epc", epc_o, 32'h8000_000c);
        chk("nested_exccode", {27'd0, cause_o[6:2]}, 32'd5);
        exc(32'he, 32'd0, 1'b0, 32'd0); settle();
        chk("eret2_exl", {31'd0, status_o[1]}, 32'd0);
        chk("eret2_epc", epc_o, 32'h8000_000c);

        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd10);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            idle(5'd9); settle();
            seen = timer_int_o;
        end
        chk("timer_seen", {31'd0, seen}, 32'd1);
        idle(5'd13); settle();
        chk("timer_ip15", {31'd0, cause_o[15]}, 32'd1);
        mtc0(5'd11, 32'd0); settle();
        chk("timer_clear", {31'd0, timer_int_o}, 32'd0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        idle(5'd9); idle(5'd9); settle();
        chk("count_wrap", count_o, 32'd0);

        step(1'b0, 1'b1, 5'd14, 5'd14, 32'hdead_beef, g_int, 32'h8, 32'h8000_1000, 1'b0, 32'd0);
        settle();
        chk("mtc0_discard", epc_o, 32'h8000_1000);
        exc(32'he, 32'd0, 1'b0, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            bit r, we, ds;
            logic [4:0] wa;
            logic [31:0] d, code;
            r  = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 2) == 0);
            wa = regs[$urandom_range(0, 7)];
            d  = $urandom;
            if (wa == 5'd11 && $urandom_range(0, 3) != 0) d = m_count + $urandom_range(0, 20);
            if (wa == 5'd9 && $urandom_range(0, 1) == 0) d = m_compare - $urandom_range(0, 10);
            code = ($urandom_range(0, 9) < 7) ? 32'd0 : codes[$urandom_range(0, 9)];
            if ($urandom_range(0, 15) == 0) g_int = 6'($urandom);
            ds = $urandom_range(0, 1);
            step(r, we, wa, regs[$urandom_range(0, 7)], d, g_int, code, $urandom, ds, $urandom);
        end

        settle(); settle();
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
